// File: rtl/alu32_nibble_serial.sv
// Nibble-serial 32-bit ALU. It handles one 4-bit slice per clock, least-significant nibble first.
// A start/done handshake wraps each operation, which takes 10 cycles from accept to the next possible accept.
module alu32_nibble_serial (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        c,
  output logic        n,
  output logic        z,
  output logic        v
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state;
  logic [31:0] a_q, b_q, asm_q, asm_next;
  logic [2:0]  op_q, cnt;
  logic        carry;

  logic [3:0]  a_nib, b_nib, b_eff, nib;
  logic [4:0]  sum;
  logic        arith, sub, b31_eff;

  // One slice of datapath: the selected nibble through either the logic op or the ripple adder.
  always_comb begin
    arith    = op_q[2] & op_q[1];
    sub      = arith & op_q[0];
    a_nib    = a_q[{cnt, 2'b00} +: 4];
    b_nib    = b_q[{cnt, 2'b00} +: 4];
    b_eff    = sub ? ~b_nib : b_nib;
    sum      = {1'b0, a_nib} + {1'b0, b_eff} + {4'b0000, carry};
    case (op_q)
      3'b000:  nib = ~a_nib;
      3'b001:  nib = ~b_nib;
      3'b010:  nib = a_nib & b_nib;
      3'b011:  nib = a_nib | b_nib;
      3'b100:  nib = a_nib ^ b_nib;
      3'b101:  nib = ~(a_nib ^ b_nib);
      default: nib = sum[3:0];
    endcase
    asm_next = asm_q;
    asm_next[{cnt, 2'b00} +: 4] = nib;
    b31_eff  = sub ? ~b_q[31] : b_q[31];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      asm_q  <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      c      <= 1'b0;
      n      <= 1'b0;
      z      <= 1'b0;
      v      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            op_q  <= op;
            cnt   <= 3'd0;
            carry <= (op == 3'b111);
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          asm_q <= asm_next;
          if (arith) carry <= sum[4];
          cnt <= cnt + 3'd1;
          // Publish only the fully assembled word, so result never shows intermediate nibbles.
          if (cnt == 3'd7) begin
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            result <= asm_next;
            c      <= arith & sum[4];
            n      <= asm_next[31];
            z      <= ~|asm_next;
            v      <= arith && (a_q[31] == b31_eff) && (asm_next[31] != a_q[31]);
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu32_nibble_serial.sv
// Self-checking bench for alu32_nibble_serial: directed vector table, randomized ops against an
// arithmetic reference model, and hand-written handshake/reset sequences.
module tb_alu32_nibble_serial;

  logic        clk = 1'b0;
  logic        reset_n, start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done, c, n, z, v;
  logic [31:0] result;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a, b, r;
    logic        c, n, z, v;
  } vec_t;

  typedef struct {
    logic [31:0] r;
    logic        c, n, z, v;
  } exp_t;

  alu32_nibble_serial dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .c(c), .n(n), .z(z), .v(v)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model straight from the op definitions, using 33-bit arithmetic for carry.
  function automatic exp_t model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    logic [32:0] s;
    e.c = 1'b0;
    e.v = 1'b0;
    s = '0;
    case (o)
      3'd0: e.r = ~x;
      3'd1: e.r = ~y;
      3'd2: e.r = x & y;
      3'd3: e.r = x | y;
      3'd4: e.r = x ^ y;
      3'd5: e.r = ~(x ^ y);
      3'd6: begin
        s = {1'b0, x} + {1'b0, y};
        e.r = s[31:0];
        e.c = s[32];
        e.v = (x[31] == y[31]) && (e.r[31] != x[31]);
      end
      default: begin
        s = {1'b0, x} + {1'b0, ~y} + 33'd1;
        e.r = s[31:0];
        e.c = s[32];
        e.v = (x[31] != y[31]) && (e.r[31] != x[31]);
      end
    endcase
    e.n = e.r[31];
    e.z = (e.r == 32'd0);
    return e;
  endfunction

  // Launches one operation, checks busy/done timing, and scrambles the operand inputs after accept.
  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    int lat;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; op = 3'($urandom);
    check({name, "_busy_rise"}, {31'b0, busy}, 32'd1);
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, "_latency"}, 32'(lat), 32'd8);
    check({name, "_busy_fall"}, {31'b0, busy}, 32'd0);
    @(posedge clk); #1;
    check({name, "_done_fall"}, {31'b0, done}, 32'd0);
  endtask

  task automatic check_out(input string name, input exp_t e);
    check({name, "_result"}, result, e.r);
    check({name, "_cnzv"}, {28'b0, c, n, z, v}, {28'b0, e.c, e.n, e.z, e.v});
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    vec_t vecs[10];
    exp_t e;
    int pulses;
    int q[$];
    logic [2:0]  ro;
    logic [31:0] rx, ry;

    vecs[0] = '{"add_carry",  3'b110, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{"add_ovf",    3'b110, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{"sub_ovf",    3'b111, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{"sub_5m7",    3'b111, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{"xor",        3'b100, 32'hF0F0A5A5, 32'h0FF05A5A, 32'hFF00FFFF, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{"xnor",       3'b101, 32'hF0F0A5A5, 32'h0FF05A5A, 32'h00FF0000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{"and",        3'b010, 32'hF0F0A5A5, 32'h0FF05A5A, 32'h00F00000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{"or",         3'b011, 32'hF0F0A5A5, 32'h0FF05A5A, 32'hFFF0FFFF, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{"not_a",      3'b000, 32'hF0F0A5A5, 32'h0FF05A5A, 32'h0F0F5A5A, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9] = '{"not_b",      3'b001, 32'hF0F0A5A5, 32'h0FF05A5A, 32'hF00FA5A5, 1'b0, 1'b1, 1'b0, 1'b0};

    reset_n = 1'b0; start = 1'b0; op = 3'd0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_cnzv", {28'b0, c, n, z, v}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b);
      e = '{vecs[i].r, vecs[i].c, vecs[i].n, vecs[i].z, vecs[i].v};
      check_out(vecs[i].name, e);
    end

    for (int i = 0; i < 24; i++) begin
      ro = 3'($urandom);
      rx = $urandom;
      ry = (i % 4 == 0) ? rx : $urandom;
      run_op("rand", ro, rx, ry);
      check_out("rand", model(ro, rx, ry));
    end

    // A start pulse during RUN must be ignored: one done, and the first op's result.
    @(negedge clk);
    start = 1'b1; op = 3'b110; a = 32'd1; b = 32'd1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    start = 1'b1; op = 3'b111; a = 32'd100; b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    check("busy_start_pulses", 32'(pulses), 32'd1);
    check("busy_start_result", result, 32'h00000002);

    // With start held high the block re-accepts every 10 cycles.
    @(negedge clk);
    start = 1'b1; op = 3'b110; a = 32'd1; b = 32'd2;
    for (int i = 0; i < 35; i++) begin
      @(posedge clk); #1;
      if (done) q.push_back(i);
    end
    @(negedge clk);
    start = 1'b0;
    check("cadence_count", 32'(q.size()), 32'd3);
    if (q.size() >= 3) begin
      check("cadence_gap1", 32'(q[1] - q[0]), 32'd10);
      check("cadence_gap2", 32'(q[2] - q[1]), 32'd10);
      check("cadence_first", 32'(q[0]), 32'd8);
    end
    check("cadence_result", result, 32'd3);
    repeat (12) @(posedge clk);

    // Reset at E4 aborts the operation and clears outputs.
    @(negedge clk);
    start = 1'b1; op = 3'b110; a = 32'h12345678; b = 32'h11111111;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    pulses = 0;
    @(posedge clk); #1;
    if (done) pulses++;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    check("abort_pulses", 32'(pulses), 32'd0);
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_result", result, 32'd0);
    check("abort_cnzv", {28'b0, c, n, z, v}, 32'd0);
    run_op("after_abort", 3'b110, 32'd3, 32'd4);
    check_out("after_abort", '{32'd7, 1'b0, 1'b0, 1'b0, 1'b0});

    // Reset and start in the same cycle: reset wins and the request is dropped.
    @(negedge clk);
    reset_n = 1'b0; start = 1'b1; op = 3'b110; a = 32'd9; b = 32'd9;
    @(posedge clk); #1;
    check("reset_wins_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1; start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done || busy) pulses++;
    end
    check("reset_wins_idle", 32'(pulses), 32'd0);
    check("reset_wins_result", result, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
